pipeline_ctrl: RTL and testbench

//  Parametrised hazard/flow controller for the 5-stage RV32 pipeline (IF,ID,EX,MEM,WB). Owns the PC,
//  per-stage valid bits, stall/bubble/flush sequencing and forwarding selects. Adds multi-cycle EX

---
 rtl/pipeline_ctrl_if.sv | 38 +++
 rtl/pipeline_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath and its hazard/flow controller.
// The controller takes the slave side; the datapath (or a bench) takes the master side.
interface pipeline_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2;
  logic             ex_mem_read;
  logic [RA_W-1:0]  ex_rd, ex_rs1, ex_rs2;
  logic             ex_busy;
  logic [RA_W-1:0]  mem_rd, wb_rd;
  logic             mem_we, wb_we;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;

  logic [XLEN-1:0]  pc;
  logic             if_id_en, id_ex_en, ex_mem_en;
  logic [3:0]       valid;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, flush;
  logic [CNT_W-1:0] retired_cnt, stall_cnt, flush_cnt;

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
           ex_busy, mem_rd, wb_rd, mem_we, wb_we, redirect, redirect_pc,
    output pc, if_id_en, id_ex_en, ex_mem_en, valid, fwd_a, fwd_b, stall, flush,
           retired_cnt, stall_cnt, flush_cnt
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
           ex_busy, mem_rd, wb_rd, mem_we, wb_we, redirect, redirect_pc,
    input  pc, if_id_en, id_ex_en, ex_mem_en, valid, fwd_a, fwd_b, stall, flush,
           retired_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/flow controller for the 5-stage RV32 pipeline: PC, stage valids, stall/flush
// sequencing, forwarding selects and saturating performance counters.
module pipeline_ctrl #(
  parameter int          XLEN        = 32,
  parameter int          RA_W        = 5,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          FLUSH_DEPTH = 2,
  parameter int          CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_ctrl_if.slave       bus
);
  // valid bit positions: {wb, mem, ex, id}
  localparam int V_ID = 0;
  localparam int V_EX = 1;
  localparam logic KILL_EX = (FLUSH_DEPTH == 2);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [3:0]       valid_q, valid_d;
  logic [CNT_W-1:0] retired_q, stall_q, flush_q;
  logic             lu, stall, flush;

  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic            mem_ok, wb_ok,
    input logic [RA_W-1:0] mem_rd, wb_rd
  );
    if (mem_ok && mem_rd != '0 && mem_rd == rs)   return 2'b10;
    else if (wb_ok && wb_rd != '0 && wb_rd == rs) return 2'b01;
    else                                          return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && c != '1) ? c + CNT_W'(1) : c;
  endfunction

  assign lu = valid_q[V_EX] & bus.ex_mem_read & (bus.ex_rd != '0) & valid_q[V_ID] &
              ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
               (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // NOTE: every signal gets a default at the top of always_comb so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    stall   = 1'b0;
    flush   = 1'b0;
    if (bus.ex_busy) begin
      // EX holds its instruction; a bubble drains into MEM while WB keeps retiring.
      valid_d = {valid_q[2], 1'b0, valid_q[1:0]};
      stall   = 1'b1;
    end else if (bus.redirect) begin
      pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      valid_d = {valid_q[2:1], (KILL_EX ? 1'b0 : valid_q[V_ID]), 1'b0};
      flush   = 1'b1;
    end else if (lu) begin
      valid_d = {valid_q[2:1], 1'b0, valid_q[V_ID]};
      stall   = 1'b1;
    end else begin
      pc_d    = pc_q + XLEN'(4);
      valid_d = {valid_q[2:0], 1'b1};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC[XLEN-1:0];
      valid_q   <= '0;
      retired_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      retired_q <= sat_inc(retired_q, valid_q[3]);
      stall_q   <= sat_inc(stall_q, stall);
      flush_q   <= sat_inc(flush_q, flush);
    end
  end

  assign bus.pc          = pc_q;
  assign bus.valid       = valid_q;
  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.if_id_en    = ~stall;
  assign bus.id_ex_en    = ~bus.ex_busy;
  assign bus.ex_mem_en   = 1'b1;
  assign bus.fwd_a       = fwd_sel(bus.ex_rs1, valid_q[2] & bus.mem_we, valid_q[3] & bus.wb_we,
                                   bus.mem_rd, bus.wb_rd);
  assign bus.fwd_b       = fwd_sel(bus.ex_rs2, valid_q[2] & bus.mem_we, valid_q[3] & bus.wb_we,
                                   bus.mem_rd, bus.wb_rd);
  assign bus.retired_cnt = retired_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: main instance (FLUSH_DEPTH=2, 32-bit counters) and a
// second instance with FLUSH_DEPTH=1 and 3-bit counters for saturation.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.XLEN(32), .RA_W(5), .CNT_W(32)) bus ();
  pipeline_ctrl_if #(.XLEN(32), .RA_W(5), .CNT_W(3))  sbus ();

  pipeline_ctrl #(.XLEN(32), .RA_W(5), .RESET_PC(32'h0), .FLUSH_DEPTH(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  pipeline_ctrl #(.XLEN(32), .RA_W(5), .RESET_PC(32'h0), .FLUSH_DEPTH(1), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_main();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_mem_read = 0; bus.ex_rd = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_busy = 0;
    bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_we = 0; bus.wb_we = 0;
    bus.redirect = 0; bus.redirect_pc = '0;
  endtask

  task automatic clear_sat();
    sbus.id_rs1 = '0; sbus.id_rs2 = '0; sbus.id_use_rs1 = 0; sbus.id_use_rs2 = 0;
    sbus.ex_mem_read = 0; sbus.ex_rd = '0; sbus.ex_rs1 = '0; sbus.ex_rs2 = '0; sbus.ex_busy = 0;
    sbus.mem_rd = '0; sbus.wb_rd = '0; sbus.mem_we = 0; sbus.wb_we = 0;
    sbus.redirect = 0; sbus.redirect_pc = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_main();
    clear_sat();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_pc", bus.pc, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_retired", bus.retired_cnt, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_flush_cnt", bus.flush_cnt, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_ifid_en", bus.if_id_en, 1);

    // Free run: valid fills one stage per cycle, PC steps by 4.
    for (int k = 0; k < 8; k++) begin
      check($sformatf("run_pc%0d", k), bus.pc, 64'(4 * k));
      check($sformatf("run_valid%0d", k), bus.valid, (k >= 4) ? 64'hf : 64'((1 << k) - 1));
      step();
    end
    check("run_retired", bus.retired_cnt, 4);
    check("run_pc_end", bus.pc, 32'h20);

    // Near-misses: rs2 matches but unused; load into x0.
    bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs2 = 5; bus.id_use_rs2 = 0;
    #1 check("lu_rs2_unused", bus.stall, 0);
    bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_use_rs1 = 1;
    #1 check("lu_x0", bus.stall, 0);

    // Load-use hazard.
    clear_main();
    bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    #1;
    check("lu_stall", bus.stall, 1);
    check("lu_ifid_en", bus.if_id_en, 0);
    check("lu_idex_en", bus.id_ex_en, 1);
    check("lu_flush", bus.flush, 0);
    step();
    check("lu_pc_held", bus.pc, 32'h20);
    check("lu_valid", bus.valid, 4'b1101);
    check("lu_stall_cnt", bus.stall_cnt, 1);
    check("lu_once", bus.stall, 0);
    clear_main();
    step();
    check("post_lu_pc", bus.pc, 32'h24);
    check("post_lu_valid", bus.valid, 4'b1011);

    // Redirect with a simultaneous load-use: redirect wins, low PC bits dropped.
    bus.redirect = 1; bus.redirect_pc = 32'h43;
    bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs1 = 5; bus.id_use_rs1 = 1;
    #1;
    check("rd_flush", bus.flush, 1);
    check("rd_stall", bus.stall, 0);
    step();
    check("rd_pc", bus.pc, 32'h40);
    check("rd_valid", bus.valid, 4'b0100);
    check("rd_flush_cnt", bus.flush_cnt, 1);
    check("rd_stall_cnt", bus.stall_cnt, 1);
    clear_main();
    repeat (4) step();
    check("refill_pc", bus.pc, 32'h50);
    check("refill_valid", bus.valid, 4'hf);

    // Forwarding selects.
    bus.mem_rd = 7; bus.wb_rd = 7; bus.mem_we = 1; bus.wb_we = 1; bus.ex_rs1 = 7; bus.ex_rs2 = 7;
    #1 check("fwd_a_mem", bus.fwd_a, 2'b10);
    check("fwd_b_mem", bus.fwd_b, 2'b10);
    bus.mem_we = 0;
    #1 check("fwd_a_wb", bus.fwd_a, 2'b01);
    bus.mem_we = 1; bus.mem_rd = 0; bus.wb_rd = 0; bus.ex_rs1 = 0;
    #1 check("fwd_a_x0", bus.fwd_a, 2'b00);
    bus.mem_rd = 7; bus.wb_rd = 7; bus.ex_rs1 = 7; bus.ex_rs2 = 3;
    #1 check("fwd_b_none", bus.fwd_b, 2'b00);

    // Multi-cycle EX with redirect held: frozen front end, bubbles into MEM.
    bus.ex_busy = 1; bus.redirect = 1; bus.redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("busy_stall%0d", i), bus.stall, 1);
      check($sformatf("busy_flush%0d", i), bus.flush, 0);
      check($sformatf("busy_idex_en%0d", i), bus.id_ex_en, 0);
      step();
      check($sformatf("busy_pc%0d", i), bus.pc, 32'h50);
      check($sformatf("busy_mem_bubble%0d", i), bus.valid[2], 0);
      if (i == 0) check("fwd_a_mem_invalid", bus.fwd_a, 2'b01);
    end
    check("busy_valid", bus.valid, 4'b0011);
    check("busy_stall_cnt", bus.stall_cnt, 4);
    bus.ex_busy = 0;
    #1 check("busy_rd_flush", bus.flush, 1);
    step();
    check("busy_rd_pc", bus.pc, 32'h80);
    check("busy_rd_valid", bus.valid, 4'b0100);
    check("busy_rd_flush_cnt", bus.flush_cnt, 2);

    // Reset during busy + redirect discards everything.
    bus.ex_busy = 1; reset = 1;
    step();
    reset = 0;
    clear_main();
    #1;
    check("mid_rst_pc", bus.pc, 0);
    check("mid_rst_valid", bus.valid, 0);
    check("mid_rst_stall_cnt", bus.stall_cnt, 0);
    check("mid_rst_flush_cnt", bus.flush_cnt, 0);

    // Saturating 3-bit counter and single-stage flush on the second instance.
    repeat (4) step();
    check("sat_fill_valid", sbus.valid, 4'hf);
    sbus.ex_busy = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("sat_stall_cnt%0d", i), sbus.stall_cnt, (i + 1 > 7) ? 64'd7 : 64'(i + 1));
    end
    sbus.ex_busy = 0; sbus.redirect = 1; sbus.redirect_pc = 32'h100;
    step();
    clear_sat();
    check("d1_pc", sbus.pc, 32'h100);
    check("d1_valid", sbus.valid, 4'b0110);
    check("d1_flush_cnt", sbus.flush_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
